wptr_full_gen: RTL

Write-side pointer and full-flag generator for the asynchronous FIFO. It runs in the write clock domain and keeps the binary write pointer. It drives the Gray-coded write pointer that the read domain synchronizes, and the memory write address. It compares its own pointer against the read pointer already synchronized into this domain to produce a registered `full` flag, a write acknowledge and a sticky overflow error.

---
 rtl/wptr_full_gen_if.sv | 34 +++
 rtl/wptr_full_gen.sv | 97 +++++++++
 2 files changed

// File: rtl/wptr_full_gen_if.sv
// Write-side bus of the async FIFO pointer block.
// Define WPTR_ALMOST_FULL_EN to add the almost_full signal.
interface wptr_full_gen_if #(
    parameter int width = 3
);
    logic             wr_en;
    logic [width:0]   rptr_sync;
    logic [width-1:0] waddr;
    logic [width:0]   wptr_gray;
    logic             wr_ack;
    logic             full;
    logic             overflow;
`ifdef WPTR_ALMOST_FULL_EN
    logic             almost_full;
`endif

    // Producer / read-pointer source side
    modport master (
        output wr_en, rptr_sync,
        input  waddr, wptr_gray, wr_ack, full, overflow
`ifdef WPTR_ALMOST_FULL_EN
        , almost_full
`endif
    );

    // Pointer generator side
    modport slave (
        input  wr_en, rptr_sync,
        output waddr, wptr_gray, wr_ack, full, overflow
`ifdef WPTR_ALMOST_FULL_EN
        , almost_full
`endif
    );
endinterface

// File: rtl/wptr_full_gen.sv
// Write-domain pointer and full-flag generator for the asynchronous FIFO.
// Keeps the binary write pointer, publishes its registered Gray copy to the
// read-side synchronizer, and derives full / overflow against the already
// synchronized read pointer.
// Optional feature macro: WPTR_ALMOST_FULL_EN (adds a registered almost_full).
module wptr_full_gen #(
    parameter int DEPTH        = 8,
    parameter int width        = $clog2(DEPTH),
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic           clk_in,
    input  logic           rst,
    wptr_full_gen_if.slave wr_bus
);

    // Reject unusable configurations at elaboration time.
    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || width != $clog2(DEPTH) ||
            AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_param_err
            $error("wptr_full_gen: DEPTH must be a power of two >= 4, width = clog2(DEPTH), 0 <= AFULL_THRESH <= DEPTH");
        end
    endgenerate

    logic [width:0] r_wbin;
    logic [width:0] r_wptr_gray;
    logic           r_full;
    logic           r_overflow;

    logic           w_wr_ack;
    logic [width:0] w_wbin_next;
    logic [width:0] w_wgray_next;
    logic [width:0] w_rptr_full_pat;

    // A write is accepted only when not full and not in reset; this is also
    // the memory write enable.
    assign w_wr_ack     = wr_bus.wr_en & ~r_full & ~rst;
    assign w_wbin_next  = r_wbin + {{width{1'b0}}, w_wr_ack};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Full when our next pointer laps the read pointer: in Gray code that is
    // the read pointer with its two MSBs inverted.
    assign w_rptr_full_pat = {~wr_bus.rptr_sync[width:width-1], wr_bus.rptr_sync[width-2:0]};

    // Pointer, Gray pointer and flag registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_wbin      <= '0;
            r_wptr_gray <= '0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_wbin      <= w_wbin_next;
            r_wptr_gray <= w_wgray_next;
            r_full      <= (w_wgray_next == w_rptr_full_pat);
            r_overflow  <= r_overflow | (wr_bus.wr_en & r_full);
        end
    end

    assign wr_bus.waddr     = r_wbin[width-1:0];
    assign wr_bus.wptr_gray = r_wptr_gray;
    assign wr_bus.wr_ack    = w_wr_ack;
    assign wr_bus.full      = r_full;
    assign wr_bus.overflow  = r_overflow;

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [width:0] L_AFULL_LVL = AFULL_THRESH[width:0];

    logic [width:0] w_rbin;
    logic [width:0] w_fill;
    logic           r_almost_full;

    // Gray-to-binary of the read pointer: each bit is the XOR of all Gray bits
    // from the MSB down to it.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_rbin unassigned (no latch).
        w_rbin = '0;
        for (int i = 0; i <= width; i++) begin
            w_rbin[i] = ^(wr_bus.rptr_sync >> i);
        end
    end

    assign w_fill = w_wbin_next - w_rbin;

    // Registered almost-full from the post-write fill level.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_fill >= L_AFULL_LVL);
        end
    end

    assign wr_bus.almost_full = r_almost_full;
`endif

endmodule
